// File: rtl/led_chain_driver.sv
// Serial driver for a chain of up to eight one-wire RGB LEDs.
// A frame sends a snapshot of the LED colours MSB-first, LED 0 first, and then holds
// the line low for the latch gap. Requests come from the update strobe or from the
// periodic refresh timer. A request that arrives mid-frame is held as a single pending flag.
module led_chain_driver #(
    parameter int T0H_CYC     = 34,
    parameter int T1H_CYC     = 67,
    parameter int BIT_CYC     = 105,
    parameter int LATCH_CYC   = 6800,
    parameter int REFRESH_CYC = 1400000
) (
    input  logic        dataclk,
    input  logic        reset,
    input  logic        enable,
    input  logic        update,
    input  logic [3:0]  num_leds,
    input  logic [23:0] led_0,
    input  logic [23:0] led_1,
    input  logic [23:0] led_2,
    input  logic [23:0] led_3,
    input  logic [23:0] led_4,
    input  logic [23:0] led_5,
    input  logic [23:0] led_6,
    input  logic [23:0] led_7,
    output logic        led_dout,
    output logic        busy,
    output logic        frame_done
);
    localparam int CNT_MAX = (BIT_CYC > LATCH_CYC) ? BIT_CYC : LATCH_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int REF_W   = $clog2(REFRESH_CYC + 1);

    typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW, S_LATCH} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [REF_W-1:0] r_refresh;
    logic [23:0]      r_snap [8];
    logic [2:0]       r_last_led;
    logic [2:0]       r_led_idx;
    logic [4:0]       r_bit_idx;
    logic             r_pending;

    logic [3:0]       w_nleds;
    logic             w_refresh_exp;
    logic             w_request;
    logic             w_start;
    logic             w_bit;
    logic [CNT_W-1:0] w_high_last;
    logic             w_high_end;
    logic             w_bit_end;
    logic             w_last_bit;
    logic             w_latch_end;
    logic             w_dout_nxt;
    logic             w_busy_nxt;
    logic             w_done_nxt;

    // Chains longer than the eight colour inputs are clamped to eight.
    assign w_nleds       = (num_leds > 4'd8) ? 4'd8 : num_leds;
    assign w_refresh_exp = enable && (r_refresh == REF_W'(REFRESH_CYC - 1));
    assign w_request     = update || w_refresh_exp || r_pending;
    assign w_start       = (r_state == S_IDLE) && enable && (w_nleds != 4'd0) && w_request;

    // The bit counter runs across HIGH and LOW, so one bit always spans exactly BIT_CYC cycles.
    assign w_bit       = r_snap[r_led_idx][r_bit_idx];
    assign w_high_last = w_bit ? CNT_W'(T1H_CYC - 1) : CNT_W'(T0H_CYC - 1);
    assign w_high_end  = (r_cnt == w_high_last);
    assign w_bit_end   = (r_cnt == CNT_W'(BIT_CYC - 1));
    assign w_last_bit  = (r_bit_idx == 5'd0) && (r_led_idx == r_last_led);
    assign w_latch_end = (r_cnt == CNT_W'(LATCH_CYC - 1));

    // State register.
    always_ff @(posedge dataclk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_start)     w_state_nxt = S_HIGH;
            S_HIGH:  if (w_high_end)  w_state_nxt = S_LOW;
            S_LOW:   if (w_bit_end)   w_state_nxt = w_last_bit ? S_LATCH : S_HIGH;
            S_LATCH: if (w_latch_end) w_state_nxt = S_IDLE;
            default:                  w_state_nxt = S_IDLE;
        endcase
    end

    // Output decode. The outputs are computed from the next state so that they can be registered.
    always_comb begin
        w_dout_nxt = (w_state_nxt == S_HIGH);
        w_busy_nxt = (w_state_nxt != S_IDLE);
        w_done_nxt = (r_state == S_LATCH) && w_latch_end;
    end

    // Registered outputs. led_dout comes straight from a flop, so it cannot glitch.
    always_ff @(posedge dataclk or posedge reset) begin
        if (reset) begin
            led_dout   <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            led_dout   <= w_dout_nxt;
            busy       <= w_busy_nxt;
            frame_done <= w_done_nxt;
        end
    end

    // Snapshot at frame start, then step the cycle, bit and LED counters through the frame.
    always_ff @(posedge dataclk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) r_snap[i] <= '0;
            r_cnt      <= '0;
            r_led_idx  <= '0;
            r_bit_idx  <= '0;
            r_last_led <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (w_start) begin
                        r_snap[0]  <= led_0;
                        r_snap[1]  <= led_1;
                        r_snap[2]  <= led_2;
                        r_snap[3]  <= led_3;
                        r_snap[4]  <= led_4;
                        r_snap[5]  <= led_5;
                        r_snap[6]  <= led_6;
                        r_snap[7]  <= led_7;
                        r_last_led <= 3'(w_nleds - 4'd1);
                        r_led_idx  <= '0;
                        r_bit_idx  <= 5'd23;
                    end
                end
                S_HIGH: r_cnt <= r_cnt + CNT_W'(1);
                S_LOW: begin
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        if (!w_last_bit) begin
                            if (r_bit_idx == 5'd0) begin
                                r_bit_idx <= 5'd23;
                                r_led_idx <= r_led_idx + 3'd1;
                            end else begin
                                r_bit_idx <= r_bit_idx - 5'd1;
                            end
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_LATCH: r_cnt <= w_latch_end ? '0 : r_cnt + CNT_W'(1);
                default: r_cnt <= '0;
            endcase
        end
    end

    // Refresh timer and the single-entry pending request. Both are cleared while the driver is disabled.
    always_ff @(posedge dataclk or posedge reset) begin
        if (reset) begin
            r_refresh <= '0;
            r_pending <= 1'b0;
        end else if (!enable) begin
            r_refresh <= '0;
            r_pending <= 1'b0;
        end else begin
            r_refresh <= w_refresh_exp ? '0 : r_refresh + REF_W'(1);
            if (r_state == S_IDLE)
                r_pending <= 1'b0;
            else if (update || w_refresh_exp)
                r_pending <= 1'b1;
        end
    end

endmodule

// File: tb/tb_led_chain_driver.sv
// Bench for led_chain_driver. It uses three instances:
//   u_slow - default timing, for the exact waveform of a single-LED frame
//   u_dut  - short timing, for the queue-scoreboarded frame tests
//   u_ref  - short timing with a 1000-cycle refresh period
module tb_led_chain_driver;
    localparam int T0F = 2;
    localparam int T1F = 4;
    localparam int BF  = 6;
    localparam int LF  = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        upd = 1'b0;
    logic        en_r = 1'b0;
    logic        upd_r = 1'b0;
    logic [3:0]  num = 4'd0;
    logic [23:0] led [8];
    logic        s_dout, s_busy, s_done;
    logic        d_dout, d_busy, d_done;
    logic        r_dout, r_busy, r_done;

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    int run_q[$];
    int done_cnt = 0;
    int ref_starts = 0;
    int ref_done = 0;

    always #5 clk = ~clk;

    led_chain_driver u_slow (
        .dataclk(clk), .reset(rst), .enable(en), .update(upd), .num_leds(num),
        .led_0(led[0]), .led_1(led[1]), .led_2(led[2]), .led_3(led[3]),
        .led_4(led[4]), .led_5(led[5]), .led_6(led[6]), .led_7(led[7]),
        .led_dout(s_dout), .busy(s_busy), .frame_done(s_done)
    );

    led_chain_driver #(.T0H_CYC(T0F), .T1H_CYC(T1F), .BIT_CYC(BF), .LATCH_CYC(LF),
                       .REFRESH_CYC(100000)) u_dut (
        .dataclk(clk), .reset(rst), .enable(en), .update(upd), .num_leds(num),
        .led_0(led[0]), .led_1(led[1]), .led_2(led[2]), .led_3(led[3]),
        .led_4(led[4]), .led_5(led[5]), .led_6(led[6]), .led_7(led[7]),
        .led_dout(d_dout), .busy(d_busy), .frame_done(d_done)
    );

    led_chain_driver #(.T0H_CYC(T0F), .T1H_CYC(T1F), .BIT_CYC(BF), .LATCH_CYC(LF),
                       .REFRESH_CYC(1000)) u_ref (
        .dataclk(clk), .reset(rst), .enable(en_r), .update(upd_r), .num_leds(num),
        .led_0(led[0]), .led_1(led[1]), .led_2(led[2]), .led_3(led[3]),
        .led_4(led[4]), .led_5(led[5]), .led_6(led[6]), .led_7(led[7]),
        .led_dout(r_dout), .busy(r_busy), .frame_done(r_done)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse;
        upd = 1'b1;
        tick;
        upd = 1'b0;
    endtask

    task automatic push_frame(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(int'(led[i]));
    endtask

    task automatic wait_done(output int n, input string tag);
        n = 0;
        while (!d_done && n < 5000) begin
            tick;
            n++;
        end
        chk(tag, int'(d_done), 1);
    endtask

    task automatic run_len(input logic lvl, output int n);
        n = 0;
        while (s_dout === lvl && n < 8000) begin
            n++;
            tick;
        end
    endtask

    // Decode u_dut's serial stream into words and compare each one with the scoreboard queue.
    initial begin
        int hi = 0, lo = 0, nb = 0, last_hi = 0;
        logic [23:0] word = '0;
        logic prev = 1'b0, inframe = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hi = 0; lo = 0; nb = 0; word = '0; prev = 1'b0; inframe = 1'b0;
            end else begin
                if (d_done) begin
                    done_cnt++;
                    chk("done_low_time", lo, BF - last_hi + LF);
                    chk("done_bit_align", nb, 0);
                    inframe = 1'b0;
                end
                if (d_dout) begin
                    if (!prev) begin
                        if (inframe) chk("low_time", lo, BF - last_hi);
                        inframe = 1'b1;
                        hi = 0;
                    end
                    hi++;
                end else if (prev) begin
                    chk("high_time", int'((hi == T0F) || (hi == T1F)), 1);
                    word = {word[22:0], (hi == T1F)};
                    nb++;
                    last_hi = hi;
                    lo = 1;
                    if (nb == 24) begin
                        if (exp_q.size() == 0) chk("word_unexpected", exp_q.size(), 1);
                        else chk("word", int'(word), exp_q.pop_front());
                        nb = 0;
                    end
                end else begin
                    lo++;
                end
                prev = d_dout;
            end
        end
    end

    // Count frame starts and frame ends on u_ref.
    initial begin
        logic prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) prev = 1'b0;
            else begin
                if (r_busy && !prev) ref_starts++;
                if (r_done) ref_done++;
                prev = r_busy;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, tot, dc, rs, rd;
        for (int i = 0; i < 8; i++) led[i] = '0;
        repeat (3) tick;
        chk("rst_slow_dout", int'(s_dout), 0);
        chk("rst_slow_busy", int'(s_busy), 0);
        chk("rst_slow_done", int'(s_done), 0);
        chk("rst_dut_dout", int'(d_dout), 0);
        chk("rst_dut_busy", int'(d_busy), 0);
        chk("rst_ref_busy", int'(r_busy), 0);
        rst = 1'b0;
        en = 1'b1;
        repeat (5) tick;
        chk("idle_no_frame", int'(d_busy), 0);

        // Single LED 0x800001 at default timing.
        num = 4'd1;
        led[0] = 24'h800001;
        push_frame(1);
        run_q.push_back(67); run_q.push_back(38);
        for (int i = 0; i < 22; i++) begin run_q.push_back(34); run_q.push_back(71); end
        run_q.push_back(67);
        pulse;
        chk("slow_latency_busy", int'(s_busy), 1);
        tot = 0;
        for (int i = 0; i < 47; i++) begin
            run_len(((i % 2) == 0), n);
            tot += n;
            chk("slow_run", n, run_q.pop_front());
        end
        n = 0;
        while (!s_done && n < 8000) begin tick; n++; end
        tot += n;
        chk("slow_latch_low", n, 38 + 6800);
        chk("slow_done", int'(s_done), 1);
        chk("slow_done_busy", int'(s_busy), 0);
        chk("slow_frame_total", tot, 24 * 105 + 6800);
        tick;
        chk("slow_done_pulse", int'(s_done), 0);
        chk("q_after_slow", exp_q.size(), 0);

        // Eight LEDs with three update pulses mid-frame: exactly one follow-up frame.
        num = 4'd8;
        for (int i = 0; i < 8; i++) led[i] = 24'($urandom());
        push_frame(8);
        pulse;
        chk("f1_busy", int'(d_busy), 1);
        repeat (100) tick; pulse;
        repeat (400) tick; pulse;
        repeat (400) tick; pulse;
        push_frame(8);
        wait_done(n, "f1_done");
        chk("gap_busy", int'(d_busy), 0);
        tick;
        chk("f2_busy", int'(d_busy), 1);
        chk("f2_dout", int'(d_dout), 1);
        wait_done(n, "f2_done");
        chk("f2_busy_len", n, 8 * 24 * BF + LF);
        tick;
        chk("no_f3_busy", int'(d_busy), 0);
        dc = done_cnt;
        repeat (200) tick;
        chk("no_f3_idle", int'(d_busy), 0);
        chk("no_f3_done", done_cnt, dc);
        chk("q_after_merge", exp_q.size(), 0);

        // A change to led_3 mid-frame shows up only in the next frame.
        num = 4'd4;
        for (int i = 0; i < 8; i++) led[i] = 24'($urandom());
        led[3] = 24'hA5C33C;
        push_frame(4);
        pulse;
        repeat (50) tick;
        led[3] = 24'h5A0FF0;
        wait_done(n, "snap_f1_done");
        tick;
        push_frame(4);
        pulse;
        wait_done(n, "snap_f2_done");
        tick;
        chk("q_after_snap", exp_q.size(), 0);

        // Asynchronous reset during bit 10 of LED 2.
        num = 4'd3;
        push_frame(3);
        pulse;
        repeat (2 * 24 * BF + 13 * BF + 2) tick;
        chk("pre_rst_dout", int'(d_dout), 1);
        rst = 1'b1;
        #1;
        chk("rst_mid_dout", int'(d_dout), 0);
        chk("rst_mid_busy", int'(d_busy), 0);
        chk("rst_mid_done", int'(d_done), 0);
        tick;
        rst = 1'b0;
        exp_q.delete();
        dc = done_cnt;
        repeat (400) tick;
        chk("post_rst_idle", int'(d_busy), 0);
        chk("post_rst_no_done", done_cnt, dc);
        push_frame(3);
        pulse;
        chk("post_rst_restart", int'(d_busy), 1);
        wait_done(n, "post_rst_done");
        chk("post_rst_len", n, 3 * 24 * BF + LF);
        tick;

        // Chain length above eight is clamped to eight.
        num = 4'd15;
        push_frame(8);
        pulse;
        wait_done(n, "clamp_done");
        chk("clamp_len", n, 8 * 24 * BF + LF);
        tick;

        // Enable drops with a request pending: the current frame completes and nothing follows.
        num = 4'd2;
        push_frame(2);
        pulse;
        repeat (20) tick; pulse;
        repeat (20) tick;
        en = 1'b0;
        wait_done(n, "en_drop_done");
        tick;
        chk("en_drop_idle", int'(d_busy), 0);
        dc = done_cnt;
        repeat (400) tick;
        chk("en_drop_no_frame", int'(d_busy), 0);
        chk("en_drop_no_done", done_cnt, dc);
        chk("q_after_en_drop", exp_q.size(), 0);

        // Refresh every 1000 cycles, and no frames while num_leds = 0.
        num = 4'd1;
        en_r = 1'b1;
        n = 0;
        while (!r_busy && n < 1200) begin tick; n++; end
        chk("refresh_first", n, 1000);
        for (int k = 0; k < 2; k++) begin
            n = 0;
            while (r_busy && n < 1200) begin tick; n++; end
            while (!r_busy && n < 1200) begin tick; n++; end
            chk("refresh_period", n, 1000);
        end
        chk("refresh_done_cnt", ref_done, 2);
        repeat (200) tick;
        num = 4'd0;
        rs = ref_starts;
        rd = ref_done;
        repeat (2500) tick;
        chk("zero_leds_no_start", ref_starts, rs);
        chk("zero_leds_no_done", ref_done, rd);
        chk("zero_leds_idle", int'(r_busy), 0);
        en_r = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/led_chain_driver.md
LED_CHAIN_DRIVER -- requirements
Module: led_chain_driver

Interface
REQ-001 SHALL have parameter T0H_CYC, default 34, high time of a 0 bit in dataclk cycles.
REQ-002 SHALL have parameter T1H_CYC, default 67, high time of a 1 bit in dataclk cycles.
REQ-003 SHALL have parameter BIT_CYC, default 105, total bit period in dataclk cycles (> T1H_CYC > T0H_CYC > 0).
REQ-004 SHALL have parameter LATCH_CYC, default 6800, low hold after the last bit, in dataclk cycles.
REQ-005 SHALL have parameter REFRESH_CYC, default 1400000, auto-refresh period in dataclk cycles.
REQ-006 SHALL have port dataclk  input  1  system clock.
REQ-007 SHALL have port reset  input  1  reset; asynchronous, active-high.
REQ-008 SHALL have port enable  input  1  permits frame starts.
REQ-009 SHALL have port update  input  1  single-cycle frame request.
REQ-010 SHALL have port num_leds  input  4  LEDs in chain; values above 8 treated as 8.
REQ-011 SHALL have ports led_0 … led_7  input  24 each  {G,R,B} colour per chain position, led_0 first.
REQ-012 SHALL have port led_dout  output  1  serial chain data.
REQ-013 SHALL have port busy  output  1  frame in progress, latch gap included.
REQ-014 SHALL have port frame_done  output  1  one-cycle pulse at frame end.

Function
REQ-015 SHALL implement states IDLE, HIGH, LOW, LATCH.
REQ-016 SHALL, in IDLE with enable=1, num_leds≠0 and a request present (update, pending flag or refresh expiry), snapshot led_0..led_7 and num_leds and enter HIGH on the next edge.
REQ-017 SHALL assert led_dout and busy one cycle after the request cycle (latency 1).
REQ-018 SHALL transmit LED 0 first, bit 23 first within each LED, from the snapshot only; input changes mid-frame SHALL NOT affect the frame.
REQ-019 SHALL hold led_dout high T1H_CYC cycles for a 1 bit or T0H_CYC cycles for a 0 bit (HIGH), then low for the remainder of BIT_CYC (LOW).
REQ-020 SHALL go from LOW to HIGH for the next bit with no gap, or to LATCH after bit 0 of LED num_leds-1.
REQ-021 SHALL hold led_dout low in LATCH for LATCH_CYC cycles, then return to IDLE, deassert busy and pulse frame_done in that same cycle.
REQ-022 SHALL keep busy high for exactly num_leds*24*BIT_CYC + LATCH_CYC cycles per frame.
REQ-023 SHALL set a single pending flag on update or refresh expiry while busy; further requests SHALL merge into it (no queue depth >1).
REQ-024 SHALL clear the pending flag at the frame start it causes.
REQ-025 SHALL start exactly one frame when update and refresh expiry coincide.
REQ-026 SHALL run a refresh counter while enable=1, generating a request and reloading every REFRESH_CYC cycles; enable=0 SHALL clear the counter.
REQ-027 SHALL let a frame in progress finish when enable drops; enable=0 SHALL clear the pending flag and block new starts.
REQ-028 SHALL ignore requests while num_leds=0; no frame, no frame_done, pending cleared.
REQ-029 SHALL drive led_dout low in IDLE and LATCH.
REQ-030 SHALL generate led_dout directly from a register (glitch-free).

Reset
REQ-031 SHALL, on reset, force led_dout=0, busy=0 and frame_done=0, enter IDLE, and clear the pending flag, refresh counter, bit/LED counters and snapshot, all immediately, including mid-frame.
REQ-032 SHALL, after reset release, start no frame before an update or a full REFRESH_CYC period.

Verification
REQ-033 SHALL verify: num_leds=1, led_0=24'h800001, update at cycle N -> led_dout high at N+1 for 67 cycles, low 38; next 22 bits 34 high/71 low; last bit 67/38; then 6800 low; frame_done at N+1+2520+6800.
REQ-034 SHALL verify: num_leds=8, three update pulses during a frame -> exactly one follow-up frame starting the cycle after frame_done; busy low for that single cycle only.
REQ-035 SHALL verify: led_3 changed mid-frame -> transmitted stream equals the value at frame start; next frame carries the new value.
REQ-036 SHALL verify: reset asserted during bit 10 of LED 2 -> led_dout=0 and busy=0 immediately; no frame_done; no frame until the next request.
REQ-037 SHALL verify: enable=1, no update, REFRESH_CYC=1000 (override) -> frames start every 1000 cycles when longer than a frame; num_leds=0 -> no frames, no frame_done.
REQ-038 SHALL verify: enable dropped mid-frame with pending set -> current frame completes with frame_done; no further frame while enable=0.
